// File: rtl/uart_pkg.sv
// Shared constants for the UART line receiver: ASCII terminators, FSM
// encodings and the inter-byte timeout computation.
package uart_pkg;

    localparam logic [7:0] ASCII_CR = 8'h0D;
    localparam logic [7:0] ASCII_LF = 8'h0A;

    localparam logic [3:0] S0_ENC = 4'd0;
    localparam logic [3:0] S1_ENC = 4'd1;
    localparam logic [3:0] S2_ENC = 4'd2;
    localparam logic [3:0] S3_ENC = 4'd3;
    localparam logic [3:0] S4_ENC = 4'd4;
    localparam logic [3:0] S5_ENC = 4'd5;

    typedef enum logic [3:0] {
        S0_IDLE    = S0_ENC,
        S1_RECV    = S1_ENC,
        S2_CR      = S2_ENC,
        S3_OUT     = S3_ENC,
        S4_FINISH  = S4_ENC,
        S5_DISCARD = S5_ENC
    } state_t;

    // Timer terminal value: number of sys_clk cycles in TIMEOUT_US, minus one.
    function automatic logic [31:0] max_wait_delay_clk(input int unsigned clk_freq,
                                                       input int unsigned timeout_us);
        return 32'(clk_freq / 32'd1_000_000 * timeout_us - 32'd1);
    endfunction

endpackage

// File: rtl/line_buf.sv
// Payload store: DEPTH x 8 register array, one synchronous write port and
// one asynchronous read port.
module line_buf #(
    parameter int DEPTH = 64,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          sys_clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [7:0]    wdata,
    input  logic [AW-1:0] raddr,
    output logic [7:0]    rdata
);

    logic [7:0] mem [DEPTH];

    always_ff @(posedge sys_clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/uart_line_rx.sv
// Reassembles CR-LF terminated lines from the uart_rx byte strobe and replays
// the payload (terminator stripped) over a valid/ready byte stream.
module uart_line_rx
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ   = 50_000_000,
    parameter int unsigned TIMEOUT_US = 1000,
    parameter int unsigned BUF_DEPTH  = 64
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic [7:0] rx_data,
    input  logic       rx_vld,
    output logic [7:0] out_data,
    output logic       out_vld,
    input  logic       out_ready,
    output logic       out_last,
    output logic [7:0] frame_len,
    output logic       frame_done,
    output logic       err_overflow,
    output logic       err_timeout,
    output logic       err_drop
);

    localparam int          AW       = $clog2(BUF_DEPTH);
    localparam logic [7:0]  DEPTH8   = 8'(BUF_DEPTH);
    localparam logic [31:0] MAX_WAIT = max_wait_delay_clk(CLK_FREQ, TIMEOUT_US);

    // Downstream handshake: a beat moves on a rising edge where out_vld and
    // out_ready are both high; out_data/out_last are held while out_ready is low.

    state_t        state;
    logic [7:0]    wr_cnt;
    logic [7:0]    rd_ptr;
    logic [31:0]   timer;
    logic          pend_vld;
    logic [7:0]    pend_byte;
    logic          buf_we;
    logic [AW-1:0] buf_waddr;
    logic [7:0]    buf_wdata;
    logic [7:0]    rd_byte;

    line_buf #(.DEPTH(BUF_DEPTH), .AW(AW)) u_line_buf (
        .sys_clk (sys_clk),
        .we      (buf_we),
        .waddr   (buf_waddr),
        .wdata   (buf_wdata),
        .raddr   (rd_ptr[AW-1:0]),
        .rdata   (rd_byte)
    );

    assign out_data = out_vld ? rd_byte : 8'h00;
    assign out_last = out_vld && (rd_ptr == wr_cnt - 8'd1);

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state        <= S0_IDLE;
            wr_cnt       <= '0;
            rd_ptr       <= '0;
            timer        <= '0;
            pend_vld     <= 1'b0;
            pend_byte    <= '0;
            buf_we       <= 1'b0;
            buf_waddr    <= '0;
            buf_wdata    <= '0;
            out_vld      <= 1'b0;
            frame_len    <= '0;
            frame_done   <= 1'b0;
            err_overflow <= 1'b0;
            err_timeout  <= 1'b0;
            err_drop     <= 1'b0;
        end else begin
            buf_we       <= 1'b0;
            frame_done   <= 1'b0;
            err_overflow <= 1'b0;
            err_timeout  <= 1'b0;
            err_drop     <= 1'b0;
            case (state)
                S0_IDLE: begin
                    timer <= '0;
                    if (rx_vld) begin
                        if (rx_data == ASCII_CR) begin
                            state <= S2_CR;
                        end else if (rx_data != ASCII_LF) begin
                            buf_we    <= 1'b1;
                            buf_waddr <= '0;
                            buf_wdata <= rx_data;
                            wr_cnt    <= 8'd1;
                            state     <= S1_RECV;
                        end
                    end
                end
                S1_RECV: begin
                    // Second half of a "\r<byte>" pair lands here one cycle after the strobe.
                    if (pend_vld) begin
                        pend_vld <= 1'b0;
                        timer    <= timer + 32'd1;
                        if (wr_cnt == DEPTH8) begin
                            err_overflow <= 1'b1;
                            state        <= S5_DISCARD;
                        end else begin
                            buf_we    <= 1'b1;
                            buf_waddr <= wr_cnt[AW-1:0];
                            buf_wdata <= pend_byte;
                            wr_cnt    <= wr_cnt + 8'd1;
                        end
                    end else if (rx_vld) begin
                        timer <= '0;
                        if (rx_data == ASCII_CR) begin
                            state <= S2_CR;
                        end else if (wr_cnt == DEPTH8) begin
                            err_overflow <= 1'b1;
                            state        <= S5_DISCARD;
                        end else begin
                            buf_we    <= 1'b1;
                            buf_waddr <= wr_cnt[AW-1:0];
                            buf_wdata <= rx_data;
                            wr_cnt    <= wr_cnt + 8'd1;
                        end
                    end else if (timer == MAX_WAIT) begin
                        err_timeout <= 1'b1;
                        wr_cnt      <= '0;
                        timer       <= '0;
                        state       <= S0_IDLE;
                    end else begin
                        timer <= timer + 32'd1;
                    end
                end
                S2_CR: begin
                    if (rx_vld) begin
                        timer <= '0;
                        if (rx_data == ASCII_LF) begin
                            if (wr_cnt != 8'd0) begin
                                rd_ptr  <= '0;
                                out_vld <= 1'b1;
                                state   <= S3_OUT;
                            end else begin
                                state <= S0_IDLE;
                            end
                        end else if (wr_cnt == DEPTH8) begin
                            err_overflow <= 1'b1;
                            state        <= S5_DISCARD;
                        end else begin
                            // The held "\r" turns out to be payload.
                            buf_we    <= 1'b1;
                            buf_waddr <= wr_cnt[AW-1:0];
                            buf_wdata <= ASCII_CR;
                            wr_cnt    <= wr_cnt + 8'd1;
                            if (rx_data != ASCII_CR) begin
                                pend_vld  <= 1'b1;
                                pend_byte <= rx_data;
                                state     <= S1_RECV;
                            end
                        end
                    end else if (timer == MAX_WAIT) begin
                        err_timeout <= 1'b1;
                        wr_cnt      <= '0;
                        timer       <= '0;
                        state       <= S0_IDLE;
                    end else begin
                        timer <= timer + 32'd1;
                    end
                end
                S3_OUT: begin
                    if (rx_vld) err_drop <= 1'b1;
                    if (out_ready) begin
                        if (rd_ptr == wr_cnt - 8'd1) begin
                            out_vld <= 1'b0;
                            state   <= S4_FINISH;
                        end else begin
                            rd_ptr <= rd_ptr + 8'd1;
                        end
                    end
                end
                S4_FINISH: begin
                    if (rx_vld) err_drop <= 1'b1;
                    frame_done <= 1'b1;
                    frame_len  <= wr_cnt;
                    wr_cnt     <= '0;
                    rd_ptr     <= '0;
                    state      <= S0_IDLE;
                end
                S5_DISCARD: begin
                    timer <= '0;
                    if (rx_vld && rx_data == ASCII_LF) begin
                        wr_cnt <= '0;
                        state  <= S0_IDLE;
                    end
                end
                default: state <= S0_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_line_rx.sv
// Directed bench for uart_line_rx: table of whole lines plus hand-written
// sequences for overflow, timeout, back-pressure/drop and mid-stream reset.
module tb_uart_line_rx;

    logic       sys_clk;
    logic       sys_rst_n;
    logic [7:0] rx_data;
    logic       rx_vld;
    logic [7:0] out_data;
    logic       out_vld;
    logic       out_ready;
    logic       out_last;
    logic [7:0] frame_len;
    logic       frame_done;
    logic       err_overflow;
    logic       err_timeout;
    logic       err_drop;

    uart_line_rx #(
        .CLK_FREQ   (50_000_000),
        .TIMEOUT_US (1),
        .BUF_DEPTH  (64)
    ) dut (
        .sys_clk      (sys_clk),
        .sys_rst_n    (sys_rst_n),
        .rx_data      (rx_data),
        .rx_vld       (rx_vld),
        .out_data     (out_data),
        .out_vld      (out_vld),
        .out_ready    (out_ready),
        .out_last     (out_last),
        .frame_len    (frame_len),
        .frame_done   (frame_done),
        .err_overflow (err_overflow),
        .err_timeout  (err_timeout),
        .err_drop     (err_drop)
    );

    // ---------------- clock / reset ----------------
    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard state ----------------
    int n_checks = 0;
    int n_fail   = 0;
    logic [7:0] exp_q[$];
    int done_cnt = 0, ovf_cnt = 0, to_cnt = 0, drop_cnt = 0;
    int base_done, base_ovf, base_to, base_drop;
    logic [7:0] last_len = 8'd0;
    logic       prev_stall = 1'b0;
    logic [7:0] prev_data  = 8'd0;
    logic [7:0] mon_e;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Monitor samples on the falling edge, half a cycle away from the DUT update.
    initial begin
        forever begin
            @(negedge sys_clk);
            if (!sys_rst_n) begin
                prev_stall = 1'b0;
                continue;
            end
            if (prev_stall) begin
                check("hold_vld", out_vld, 1);
                check("hold_data", out_data, prev_data);
            end
            prev_stall = out_vld && !out_ready;
            prev_data  = out_data;
            if (out_vld && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL extra_beat: got data %02h, expected no beat", out_data);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("out_data", out_data, mon_e);
                    check("out_last", out_last, exp_q.size() == 0);
                end
            end
            done_cnt += int'(frame_done);
            ovf_cnt  += int'(err_overflow);
            to_cnt   += int'(err_timeout);
            drop_cnt += int'(err_drop);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic idle(input int n);
        repeat (n) begin
            @(posedge sys_clk);
            #1;
        end
    endtask

    task automatic strobe(input logic [7:0] b);
        @(posedge sys_clk);
        #1;
        rx_data = b;
        rx_vld  = 1'b1;
        @(posedge sys_clk);
        #1;
        rx_vld  = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        strobe(b);
        idle(gap - 1);
    endtask

    task automatic mark();
        base_done = done_cnt;
        base_ovf  = ovf_cnt;
        base_to   = to_cnt;
        base_drop = drop_cnt;
    endtask

    task automatic check_line(input int d_done, input int d_ovf, input int d_to, input int d_drop);
        for (int c = 0; c < 400; c++) begin
            if (exp_q.size() == 0 && done_cnt == base_done + d_done) break;
            idle(1);
        end
        idle(20);
        check("beats_left", exp_q.size(), 0);
        check("frame_done_cnt", done_cnt - base_done, d_done);
        check("frame_len", frame_len, last_len);
        check("err_overflow_cnt", ovf_cnt - base_ovf, d_ovf);
        check("err_timeout_cnt", to_cnt - base_to, d_to);
        check("err_drop_cnt", drop_cnt - base_drop, d_drop);
        exp_q.delete();
        mark();
    endtask

    // ---------------- vector table ----------------
    typedef struct packed {
        logic [63:0] in_b;
        logic [3:0]  n_in;
        logic [63:0] exp_b;
        logic [3:0]  n_exp;
        logic [7:0]  exp_len;
        logic        exp_done;
    } vec_t;

    vec_t vecs[6];

    task automatic run_vec(input vec_t v);
        mark();
        for (int i = 0; i < int'(v.n_exp); i++) exp_q.push_back(v.exp_b[8*i +: 8]);
        for (int i = 0; i < int'(v.n_in); i++) send_byte(v.in_b[8*i +: 8], 10);
        if (v.exp_done) last_len = v.exp_len;
        check_line(int'(v.exp_done), 0, 0, 0);
    endtask

    initial begin
        // "AB\r\n", "\r\n", "\n", "A\rB\r\n", "\r\r\n", "h\n\r\n" (byte 0 in the low lane)
        vecs[0] = '{in_b: 64'h0A0D4241,   n_in: 4'd4, exp_b: 64'h4241,   n_exp: 4'd2, exp_len: 8'd2, exp_done: 1'b1};
        vecs[1] = '{in_b: 64'h0A0D,       n_in: 4'd2, exp_b: 64'h0,      n_exp: 4'd0, exp_len: 8'd0, exp_done: 1'b0};
        vecs[2] = '{in_b: 64'h0A,         n_in: 4'd1, exp_b: 64'h0,      n_exp: 4'd0, exp_len: 8'd0, exp_done: 1'b0};
        vecs[3] = '{in_b: 64'h0A0D420D41, n_in: 4'd5, exp_b: 64'h420D41, n_exp: 4'd3, exp_len: 8'd3, exp_done: 1'b1};
        vecs[4] = '{in_b: 64'h0A0D0D,     n_in: 4'd3, exp_b: 64'h0D,     n_exp: 4'd1, exp_len: 8'd1, exp_done: 1'b1};
        vecs[5] = '{in_b: 64'h0A0D0A68,   n_in: 4'd4, exp_b: 64'h0A68,   n_exp: 4'd2, exp_len: 8'd2, exp_done: 1'b1};

        rx_data   = 8'h00;
        rx_vld    = 1'b0;
        out_ready = 1'b1;
        sys_rst_n = 1'b0;
        idle(3);
        check("rst_out_vld", out_vld, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_last", out_last, 0);
        check("rst_frame_len", frame_len, 0);
        check("rst_frame_done", frame_done, 0);
        check("rst_err_overflow", err_overflow, 0);
        check("rst_err_timeout", err_timeout, 0);
        check("rst_err_drop", err_drop, 0);
        sys_rst_n = 1'b1;
        idle(2);

        for (int v = 0; v < 6; v++) run_vec(vecs[v]);

        // Exactly BUF_DEPTH bytes is a legal line.
        mark();
        for (int i = 0; i < 64; i++) exp_q.push_back(8'h78);
        for (int i = 0; i < 64; i++) send_byte(8'h78, 10);
        send_byte(8'h0D, 10);
        send_byte(8'h0A, 10);
        last_len = 8'd64;
        check_line(1, 0, 0, 0);

        // Byte 65 overflows; the discard state ignores the timeout.
        for (int i = 0; i < 64; i++) send_byte(8'h78, 10);
        check("ovf_early", ovf_cnt - base_ovf, 0);
        strobe(8'h78);
        check("ovf_pulse", err_overflow, 1);
        idle(80);
        send_byte(8'h0D, 10);
        send_byte(8'h0A, 10);
        check_line(0, 1, 0, 0);
        exp_q.push_back(8'h5A);
        send_byte(8'h5A, 10);
        send_byte(8'h0D, 10);
        send_byte(8'h0A, 10);
        last_len = 8'd1;
        check_line(1, 0, 0, 0);

        // Timeout fires exactly 50 cycles after the last strobe.
        send_byte(8'h41, 10);
        strobe(8'h42);
        idle(49);
        check("timeout_early", err_timeout, 0);
        idle(1);
        check("timeout_pulse", err_timeout, 1);
        idle(1);
        check("timeout_width", err_timeout, 0);
        exp_q.push_back(8'h43);
        send_byte(8'h43, 10);
        send_byte(8'h0D, 10);
        send_byte(8'h0A, 10);
        last_len = 8'd1;
        check_line(1, 0, 1, 0);

        // Back-pressure toggling every cycle, one byte injected mid-stream.
        exp_q.push_back(8'h41);
        exp_q.push_back(8'h42);
        exp_q.push_back(8'h43);
        fork
            begin
                for (int c = 0; c < 80; c++) begin
                    @(posedge sys_clk);
                    #1;
                    out_ready = ~out_ready;
                end
            end
            begin
                send_byte(8'h41, 10);
                send_byte(8'h42, 10);
                send_byte(8'h43, 10);
                send_byte(8'h0D, 10);
                strobe(8'h0A);
                strobe(8'h51);
                idle(20);
            end
        join
        out_ready = 1'b1;
        last_len = 8'd3;
        check_line(1, 0, 0, 1);

        // Reset while a line is being presented aborts it silently.
        out_ready = 1'b0;
        send_byte(8'h41, 10);
        send_byte(8'h42, 10);
        send_byte(8'h43, 10);
        send_byte(8'h0D, 10);
        send_byte(8'h0A, 4);
        check("stream_vld", out_vld, 1);
        check("stream_data", out_data, 8'h41);
        check("stream_last", out_last, 0);
        sys_rst_n = 1'b0;
        #1;
        check("midrst_out_vld", out_vld, 0);
        check("midrst_out_data", out_data, 0);
        check("midrst_out_last", out_last, 0);
        check("midrst_frame_len", frame_len, 0);
        check("midrst_frame_done", frame_done, 0);
        idle(3);
        sys_rst_n = 1'b1;
        out_ready = 1'b1;
        last_len = 8'd0;
        check_line(0, 0, 0, 0);

        exp_q.push_back(8'h5A);
        send_byte(8'h5A, 10);
        send_byte(8'h0D, 10);
        send_byte(8'h0A, 10);
        last_len = 8'd1;
        check_line(1, 0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
